// File: rtl/acumulador_palavras_pkg.sv
// Shared definitions for the halfword accumulator: FSM states, halfword order, width bounds.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package acumulador_palavras_pkg;

  // Legal range of the accumulator width parameter
  localparam int ACC_W_MIN   = 17;
  localparam int ACC_W_MAX   = 48;
  // Legal range of the frame length, and the pair counter width that holds it
  localparam int N_PARES_MAX = 65535;
  localparam int CNT_W       = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SOMA0 = 3'd1,
    SOMA1 = 3'd2,
    SOMA2 = 3'd3,
    SOMA3 = 3'd4,
    SAIDA = 3'd5
  } estado_t;

  // {sel_entrada, sel_palavra} for each add step: e0 high, e0 low, e1 high, e1 low
  localparam logic [1:0] ORDEM_SEL [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  // Separator selects for the halfword added in a given state (don't-care outside SOMAx)
  function automatic logic [1:0] sel_do_estado(input estado_t e);
    case (e)
      SOMA0:   return ORDEM_SEL[0];
      SOMA1:   return ORDEM_SEL[1];
      SOMA2:   return ORDEM_SEL[2];
      SOMA3:   return ORDEM_SEL[3];
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/acumulador_palavras_separador.sv
// 16-bit separator: picks one halfword out of a pair of 32-bit words.
// Latency: combinational.
// Backpressure: none; output follows the selects.
module acumulador_palavras_separador (
  input  logic [31:0] palavra_0,
  input  logic [31:0] palavra_1,
  input  logic        sel_entrada,
  input  logic        sel_palavra,
  output logic [15:0] meia
);

  logic [31:0] palavra;

  assign palavra = sel_entrada ? palavra_1 : palavra_0;

  // Halfword select is Gray-coded against sel_entrada: equal selects give the high
  // half, differing selects the low half, so the sequence 00,01,11,10 walks
  // e0 high, e0 low, e1 high, e1 low with one select bit changing per step.
  assign meia = (sel_entrada ^ sel_palavra) ? palavra[15:0] : palavra[31:16];

endmodule

// File: rtl/acumulador_palavras.sv
// Accumulates the four sign-extended halfwords of N_PARES word pairs into one signed frame sum.
// Latency: one pair per 5 cycles; out_valid 5 cycles after the last pair is accepted.
// Backpressure: in_ready only in IDLE; result held in SAIDA until out_ready. Macro: ACUMULADOR_SATURACAO_EN.
module acumulador_palavras #(
  parameter int ACC_W   = 32,
  parameter int N_PARES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             limpar,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      entrada_0,
  input  logic [31:0]      entrada_1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_soma,
  output logic             out_saturou
);

  import acumulador_palavras_pkg::*;

  if (ACC_W < ACC_W_MIN || ACC_W > ACC_W_MAX || N_PARES < 1 || N_PARES > N_PARES_MAX) begin : g_param_invalido
    $error("acumulador_palavras: ACC_W or N_PARES out of range");
  end

  localparam logic [CNT_W-1:0] N_PARES_C = CNT_W'(N_PARES);

  estado_t          estado;
  estado_t          estado_prox;
  logic [31:0]      reg_0;
  logic [31:0]      reg_1;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_prox;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_prox;
  logic             sel_entrada;
  logic             sel_palavra;
  logic [15:0]      meia;
  logic             captura;
  logic             soma_en;
  logic             conta;
  logic             zera;

  assign cnt_prox                  = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign {sel_entrada, sel_palavra} = sel_do_estado(estado);
  assign out_soma                  = acc;

  acumulador_palavras_separador u_separador (
    .palavra_0   (reg_0),
    .palavra_1   (reg_1),
    .sel_entrada (sel_entrada),
    .sel_palavra (sel_palavra),
    .meia        (meia)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) estado <= IDLE;
    else          estado <= estado_prox;
  end

  // Next state and control strobes; limpar overrides everything at the end
  always_comb begin
    estado_prox = estado;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    captura     = 1'b0;
    soma_en     = 1'b0;
    conta       = 1'b0;
    zera        = 1'b0;
    case (estado)
      IDLE: begin
        in_ready = !limpar;
        if (in_valid) begin
          captura     = 1'b1;
          estado_prox = SOMA0;
        end
      end
      SOMA0: begin
        soma_en     = 1'b1;
        estado_prox = SOMA1;
      end
      SOMA1: begin
        soma_en     = 1'b1;
        estado_prox = SOMA2;
      end
      SOMA2: begin
        soma_en     = 1'b1;
        estado_prox = SOMA3;
      end
      SOMA3: begin
        soma_en     = 1'b1;
        conta       = 1'b1;
        estado_prox = (cnt_prox == N_PARES_C) ? SAIDA : IDLE;
      end
      SAIDA: begin
        out_valid = 1'b1;
        if (out_ready) begin
          zera        = 1'b1;
          estado_prox = IDLE;
        end
      end
      default: estado_prox = IDLE;
    endcase
    if (limpar) begin
      estado_prox = IDLE;
      zera        = 1'b1;
      captura     = 1'b0;
      soma_en     = 1'b0;
      conta       = 1'b0;
    end
  end

  // Pair capture, accumulator and pair counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_0 <= '0;
      reg_1 <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      if (captura) begin
        reg_0 <= entrada_0;
        reg_1 <= entrada_1;
      end
      if (zera) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        if (soma_en) acc <= acc_prox;
        if (conta)   cnt <= cnt_prox;
      end
    end
  end

`ifdef ACUMULADOR_SATURACAO_EN
  logic [ACC_W:0] soma_larga;
  logic           estourou;
  logic           saturou;

  // One guard bit catches overflow; clamp toward the sign of the true sum
  always_comb begin
    soma_larga = {acc[ACC_W-1], acc} + {{(ACC_W-15){meia[15]}}, meia};
    estourou   = soma_larga[ACC_W] != soma_larga[ACC_W-1];
    if (!estourou)              acc_prox = soma_larga[ACC_W-1:0];
    else if (soma_larga[ACC_W]) acc_prox = {1'b1, {(ACC_W-1){1'b0}}};
    else                        acc_prox = {1'b0, {(ACC_W-1){1'b1}}};
  end

  // Sticky clamp flag, cleared together with the frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 saturou <= 1'b0;
    else if (zera)                saturou <= 1'b0;
    else if (soma_en && estourou) saturou <= 1'b1;
  end

  assign out_saturou = saturou;
`else
  // Plain two's-complement wrap
  assign acc_prox    = acc + {{(ACC_W-16){meia[15]}}, meia};
  assign out_saturou = 1'b0;
`endif

endmodule

// File: tb/tb_acumulador_palavras.sv
// Directed bench: three instances (N_PARES=2, N_PARES=1, ACC_W=18/N_PARES=4).
// Inputs are driven and outputs sampled on the falling clock edge.
// Saturation expectations follow ACUMULADOR_SATURACAO_EN.
module tb_acumulador_palavras;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        limpar;
  logic [31:0] e0;
  logic [31:0] e1;
  logic        out_ready;

  logic        iv_a, rdy_a, ov_a, sat_a;
  logic [31:0] soma_a;
  logic        iv_b, rdy_b, ov_b, sat_b;
  logic [31:0] soma_b;
  logic        iv_c, rdy_c, ov_c, sat_c;
  logic [17:0] soma_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  acumulador_palavras #(.ACC_W(32), .N_PARES(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .limpar(limpar), .in_valid(iv_a), .in_ready(rdy_a),
    .entrada_0(e0), .entrada_1(e1), .out_valid(ov_a), .out_ready(out_ready),
    .out_soma(soma_a), .out_saturou(sat_a));

  acumulador_palavras #(.ACC_W(32), .N_PARES(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .limpar(limpar), .in_valid(iv_b), .in_ready(rdy_b),
    .entrada_0(e0), .entrada_1(e1), .out_valid(ov_b), .out_ready(out_ready),
    .out_soma(soma_b), .out_saturou(sat_b));

  acumulador_palavras #(.ACC_W(18), .N_PARES(4)) dut_c (
    .clk(clk), .reset_n(reset_n), .limpar(limpar), .in_valid(iv_c), .in_ready(rdy_c),
    .entrada_0(e0), .entrada_1(e1), .out_valid(ov_c), .out_ready(out_ready),
    .out_soma(soma_c), .out_saturou(sat_c));

  task automatic verifica(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel_rdy(input int q);
    case (q)
      0:       return rdy_a;
      1:       return rdy_b;
      default: return rdy_c;
    endcase
  endfunction

  function automatic logic sel_ov(input int q);
    case (q)
      0:       return ov_a;
      1:       return ov_b;
      default: return ov_c;
    endcase
  endfunction

  // Called on a falling edge; waits (bounded) for in_ready, then offers one pair
  task automatic envia(input int q, input logic [31:0] a, input logic [31:0] b);
    int espera;
    espera = 0;
    while (!sel_rdy(q) && espera < 20) begin
      @(negedge clk);
      espera++;
    end
    verifica("envia_in_ready", {63'd0, sel_rdy(q)}, 64'd1);
    if (sel_rdy(q)) begin
      e0 = a;
      e1 = b;
      case (q)
        0:       iv_a = 1'b1;
        1:       iv_b = 1'b1;
        default: iv_c = 1'b1;
      endcase
      @(negedge clk);
      iv_a = 1'b0;
      iv_b = 1'b0;
      iv_c = 1'b0;
    end
  endtask

  // Entered one cycle after the accept; out_valid must rise exactly at accept+5
  task automatic espera_saida(input int q, input string tag);
    for (int i = 0; i < 4; i++) begin
      verifica({tag, "_cedo"}, {63'd0, sel_ov(q)}, 64'd0);
      if (i < 3) @(negedge clk);
    end
    @(negedge clk);
    verifica({tag, "_ov"}, {63'd0, sel_ov(q)}, 64'd1);
  endtask

  task automatic consome;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    limpar    = 1'b0;
    e0        = '0;
    e1        = '0;
    out_ready = 1'b0;
    iv_a      = 1'b0;
    iv_b      = 1'b0;
    iv_c      = 1'b0;

    // Reset state
    #12;
    verifica("rst_ov_a",   {63'd0, ov_a}, 64'd0);
    verifica("rst_soma_a", {32'd0, soma_a}, 64'd0);
    verifica("rst_sat_c",  {63'd0, sat_c}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    verifica("rst_rdy_a", {63'd0, rdy_a}, 64'd1);
    verifica("rst_rdy_c", {63'd0, rdy_c}, 64'd1);

    // Two-pair frame: 1+2+3+4 then zeros = 10, latency 5 from the last accept
    envia(0, 32'h0001_0002, 32'h0003_0004);
    envia(0, 32'h0000_0000, 32'h0000_0000);
    espera_saida(0, "frame2");
    verifica("frame2_soma", {32'd0, soma_a}, 64'd10);
    verifica("frame2_sat",  {63'd0, sat_a}, 64'd0);

    // Result held while the consumer stalls
    for (int i = 0; i < 5; i++) begin
      verifica("hold_ov",   {63'd0, ov_a}, 64'd1);
      verifica("hold_soma", {32'd0, soma_a}, 64'd10);
      verifica("hold_rdy",  {63'd0, rdy_a}, 64'd0);
      @(negedge clk);
    end
    consome();
    verifica("hs_ov",   {63'd0, ov_a}, 64'd0);
    verifica("hs_soma", {32'd0, soma_a}, 64'd0);
    verifica("hs_rdy",  {63'd0, rdy_a}, 64'd1);

    // Sign extension of every halfword: -1 -1 -32768 +1 = -32769
    envia(1, 32'hFFFF_FFFF, 32'h8000_0001);
    espera_saida(1, "sext");
    verifica("sext_soma", {32'd0, soma_b}, 64'h0000_0000_FFFF_7FFF);
    consome();
    verifica("sext_hs_soma", {32'd0, soma_b}, 64'd0);

    // limpar during SOMA2 drops the partial sum
    envia(0, 32'h0005_0005, 32'h0005_0005);
    @(negedge clk);
    @(negedge clk);
    verifica("lim_parcial", {32'd0, soma_a}, 64'd10);
    limpar = 1'b1;
    @(posedge clk);
    #1 limpar = 1'b0;
    @(negedge clk);
    verifica("lim_soma", {32'd0, soma_a}, 64'd0);
    verifica("lim_rdy",  {63'd0, rdy_a}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      verifica("lim_sem_ov", {63'd0, ov_a}, 64'd0);
      @(negedge clk);
    end
    envia(0, 32'h0001_0001, 32'h0001_0001);
    envia(0, 32'h0002_0000, 32'h0000_0003);
    espera_saida(0, "pos_lim");
    verifica("pos_lim_soma", {32'd0, soma_a}, 64'd9);
    consome();

    // 16 additions of 0x7FFF into an 18-bit accumulator
    for (int i = 0; i < 4; i++) envia(2, 32'h7FFF_7FFF, 32'h7FFF_7FFF);
    espera_saida(2, "sat");
`ifdef ACUMULADOR_SATURACAO_EN
    verifica("sat_soma", {46'd0, soma_c}, 64'h1FFFF);
    verifica("sat_flag", {63'd0, sat_c}, 64'd1);
`else
    verifica("sat_soma", {46'd0, soma_c}, 64'h3FFF0);
    verifica("sat_flag", {63'd0, sat_c}, 64'd0);
`endif
    consome();
    verifica("sat_hs_flag", {63'd0, sat_c}, 64'd0);
    verifica("sat_hs_soma", {46'd0, soma_c}, 64'd0);

    // Asynchronous reset during SOMA1
    envia(0, 32'h0001_0001, 32'h0001_0001);
    @(negedge clk);
    verifica("arst_parcial", {32'd0, soma_a}, 64'd1);
    reset_n = 1'b0;
    #1;
    verifica("arst_soma", {32'd0, soma_a}, 64'd0);
    verifica("arst_ov",   {63'd0, ov_a}, 64'd0);
    verifica("arst_rdy",  {63'd0, rdy_a}, 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    envia(0, 32'h0002_0002, 32'h0002_0002);
    envia(0, 32'h0000_0003, 32'h0000_0000);
    espera_saida(0, "pos_arst");
    verifica("pos_arst_soma", {32'd0, soma_a}, 64'd11);
    consome();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acumulador_palavras.md
ACUMULADOR_PALAVRAS -- requirements
Module: acumulador_palavras

Interface
REQ-001 Parameter ACC_W, default 32: accumulator and result width; SHALL be 17..48.
REQ-002 Parameter N_PARES, default 16: input pairs per accumulation frame; SHALL be 1..65535.
REQ-003 Port clk, input, 1: single clock, rising edge.
REQ-004 Port reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port limpar, input, 1: synchronous frame clear.
REQ-006 Port in_valid, input, 1: entrada_0/entrada_1 pair offered.
REQ-007 Port in_ready, output, 1: block accepts a pair this cycle.
REQ-008 Port entrada_0, input, 32: first word of the pair.
REQ-009 Port entrada_1, input, 32: second word of the pair.
REQ-010 Port out_valid, output, 1: out_soma holds a completed frame sum.
REQ-011 Port out_ready, input, 1: consumer takes the result.
REQ-012 Port out_soma, output, ACC_W: signed frame sum.
REQ-013 Port out_saturou, output, 1: sticky saturation flag for the frame.

Function
REQ-014 The FSM SHALL have states IDLE, SOMA0, SOMA1, SOMA2, SOMA3 and SAIDA.
REQ-015 in_ready SHALL be 1 only in IDLE with limpar=0.
REQ-016 In IDLE, in_valid&in_ready SHALL register both words and move to SOMA0.
REQ-017 SOMA0..SOMA3 SHALL add, one per cycle, the sign-extended halfwords entrada_0[31:16], entrada_0[15:0], entrada_1[31:16], entrada_1[15:0], in that order, to the accumulator.
REQ-018 Halfword order SHALL map to separator selects as {sel_entrada,sel_palavra} = 00, 01, 11, 10.
REQ-019 After SOMA3 the pair counter SHALL increment; on reaching N_PARES the FSM SHALL enter SAIDA, otherwise IDLE.
REQ-020 Throughput SHALL be one pair per 5 cycles; accept-to-out_valid latency for the last pair SHALL be 5 cycles.
REQ-021 In SAIDA, out_valid SHALL be 1, and out_soma and out_saturou SHALL be stable until out_ready.
REQ-022 The out_valid&out_ready handshake SHALL zero the accumulator, counter and flag and return to IDLE.
REQ-023 limpar=1 SHALL, in any state, return to IDLE next cycle with accumulator, counter and flag zeroed; limpar SHALL win over every other event, including a simultaneous handshake.
REQ-024 out_soma SHALL equal the accumulator register; out_valid SHALL be 0 outside SAIDA.

Reset
REQ-025 reset_n=0 SHALL asynchronously force IDLE and zero the accumulator, counter, registered words and out_saturou; out_valid=0, out_soma=0, and in_ready=1 once reset_n=1 (with limpar=0).
REQ-026 Reset mid-frame SHALL discard the partial sum without producing an output.

Configuration
REQ-027 With macro ACUMULADOR_SATURACAO_EN defined, each addition SHALL clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1], and out_saturou SHALL set on any clamp and stay set until the frame clears.
REQ-028 Without the macro, additions SHALL wrap modulo 2^ACC_W, and out_saturou SHALL be tied to 0.

Structure
REQ-029 A shared package SHALL hold the FSM state enumeration, the halfword-order select table and the ACC_W bounds constants.
REQ-030 The halfword selection SHALL be the existing 16-bit separator module, instantiated once and driven by the FSM selects.

Verification
REQ-031 N_PARES=2; input (0x00010002, 0x00030004), then (0, 0) -> out_valid 5 cycles after the second accept, out_soma=10.
REQ-032 N_PARES=1; input (0xFFFFFFFF, 0x80000001) -> out_soma=-32769 (sign extension of every halfword).
REQ-033 Completed frame with out_ready=0 for 5 cycles -> out_valid=1, out_soma stable and in_ready=0 throughout; first out_ready=1 -> IDLE next cycle with accumulator 0.
REQ-034 limpar pulsed in SOMA2 -> IDLE next cycle, accumulator 0, no out_valid; a new frame then sums from zero.
REQ-035 ACC_W=18, N_PARES=4, all halfwords 0x7FFF -> with macro, out_soma=131071 and out_saturou=1; without macro, out_soma=0x3FFF0 (-16) and out_saturou=0.
REQ-036 reset_n dropped during SOMA1 -> outputs zero immediately without waiting for clk; after release the next frame result is unaffected.
